montgomery_param: RTL and testbench
===================================

Name: montgomery_param

Overview:
- Parametrised radix-2 Montgomery modular multiplier: result = A·B·2^(-WIDTH) mod M.
- Successor to the fixed 1024-bit multiplier, with these changes:
  - Generic WIDTH.
  - Final conditional subtraction, so result is fully reduced (< M) and WIDTH bits wide, not WIDTH+1.
  - busy output; start is ignored while busy.
  - Compile-time option that precomputes B+M to halve the iteration cycles.
- Sits under the RSA exponentiation controller. The controller drives one multiply at a time.

Parameters:
- WIDTH, 1024, operand and modulus width in bits (≥ 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  one clock; reset is synchronous and active-high.
- start  input  1  one-cycle request; sampled only in IDLE.
- in_a  input  WIDTH  multiplicand A; requires A < M.
- in_b  input  WIDTH  multiplier B; requires B < M.
- in_m  input  WIDTH  modulus M; requires odd M, M ≥ 3.
- result  output  WIDTH  A·B·R^-1 mod M, with R = 2^WIDTH; registered.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when result is valid.

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - state=IDLE.
  - result=0, busy=0, done=0.
  - Internal A/B/M/C/counter registers = 0.
  - Operation in flight is discarded; no done pulse.
- IDLE:
  - start=1 at edge k: latch in_a, in_b, in_m into internal registers; C=0; counter=0; busy=1 from cycle k+1.
  - Next state is ITER, or PRECOMP when MONT_PRECOMP_EN is defined.
  - Inputs may change after edge k without effect.
- ITER (per bit i = 0..WIDTH-1, LSB first, a_i = A[i]); C is a WIDTH+2-bit accumulator.
  - Base (two cycles per bit):
    - Phase 0: C ← C + a_i·B.
    - Phase 1: q = C[0]; C ← (C + q·M) >> 1.
  - Counter increments after phase 1; leave ITER after bit WIDTH-1.
- SUB (one cycle):
  - If C ≥ M then result ← C − M, else result ← C[WIDTH-1:0].
  - Invariant: C < 2M entering SUB.
- DONE (one cycle): done=1; busy=0 in this same cycle; return to IDLE.
  - start asserted during DONE is ignored.
  - start is accepted again from the next IDLE cycle.
- start while busy: ignored; no restart, no queueing.
- Latency: start edge k → done high during cycle k+L.
  - Base: L = 2·WIDTH + 2.
  - With MONT_PRECOMP_EN: L = WIDTH + 3.
- result holds its value until the next SUB; it is unchanged by start alone.
- Out-of-contract inputs (A ≥ M, B ≥ M, even M): result undefined, but latency and handshake are unchanged.
- Arithmetic: all adds are WIDTH+2 bits. Compare/subtract uses the borrow of a WIDTH+2-bit subtract; never truncate C before the compare.

Optional Feature:
- Macro: MONT_PRECOMP_EN.
- Defined:
  - Extra PRECOMP state (one cycle) after IDLE stores D = B + M in a WIDTH+1-bit register.
  - ITER becomes one cycle per bit: q = C[0] XOR (a_i AND B[0]).
  - Add term selected by (a_i, q): 00→0, 10→B, 01→M, 11→D.
  - C ← (C + sel) >> 1.
  - L = WIDTH + 3.
- Undefined: no D register, no PRECOMP state, two-phase ITER, L = 2·WIDTH + 2.
- Results are bit-identical in both builds.

Decomposition:
- Package montgomery_pkg:
  - State enum: IDLE, PRECOMP, ITER, SUB, DONE.
  - Default WIDTH constant.
  - Latency function lat(WIDTH), returning the build-dependent L; used by the bench.
- One sub-module, mont_cond_sub: combinational WIDTH+2-bit compare-and-subtract returning the reduced WIDTH-bit value. Reused later by the exponentiation controller.
- Iteration adders stay inline.

Test Plan:
- WIDTH=8, A=5, B=7, M=13, start pulse:
  - result=0x01, done high exactly at k+18 (base) / k+11 (precomp).
  - busy high for cycles k+1..k+L-1, low during the done cycle.
- WIDTH=8, A=12, B=12, M=13 → result=0x03.
  - A=1, B=1, M=13 → 0x03.
  - A=0, B=9, M=13 → 0x00.
- WIDTH=8, start re-pulsed at k+5 with different inputs (A=1, B=1) during A=5, B=7, M=13:
  - Ignored; result=0x01 at the original done time.
  - A new start the cycle after done is accepted.
- WIDTH=8: assert reset at k+6 mid-operation.
  - Next cycle: busy=0, result=0, no done pulse.
  - A fresh start then yields correct result and latency.
- WIDTH=1024: 200 random odd M with top bit set, A,B < M, compared against a software model.
  - All results < M; done at k+L for every vector.
  - Run in both MONT_PRECOMP_EN builds.
- WIDTH=8, A=B=M-1 for M=255 (C near 2M, exercises SUB) → result = 254·254·R^-1 mod 255 = 0x01.

Source files
------------

// File: rtl/montgomery_pkg.sv
// Shared constants for the Montgomery multiplier: FSM encodings, default width, latency.
// Build option MONT_PRECOMP_EN selects the one-cycle-per-bit datapath.
package montgomery_pkg;

  localparam int MONT_WIDTH = 1024;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PRECOMP = 3'd1;
  localparam logic [2:0] ITER    = 3'd2;
  localparam logic [2:0] SUB     = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  // Cycles from the accepting start edge to the done cycle.
  function automatic int lat(input int width);
`ifdef MONT_PRECOMP_EN
    return width + 3;
`else
    return 2 * width + 2;
`endif
  endfunction

endpackage

// File: rtl/mont_cond_sub.sv
// Final Montgomery reduction: returns C-M when C >= M, else C, for C < 2M.
// Latency: combinational. Backpressure: none.
module mont_cond_sub #(
  parameter int WIDTH = 1024
) (
  input  logic [WIDTH+1:0] c,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] res
);

  // One extra bit so the top bit is the borrow of the full-width subtract.
  logic [WIDTH+2:0] diff;
  logic [1:0]       unused_diff;

  assign diff        = {1'b0, c} - {3'b000, m};
  assign res         = diff[WIDTH+2] ? c[WIDTH-1:0] : diff[WIDTH-1:0];
  assign unused_diff = diff[WIDTH+1:WIDTH];

endmodule

// File: rtl/montgomery_param.sv
// Radix-2 Montgomery multiplier, result = A*B*2^-WIDTH mod M; MONT_PRECOMP_EN gives one cycle/bit.
// Latency: 2*WIDTH+2 (WIDTH+3 with MONT_PRECOMP_EN); start ignored while busy, no queueing.
module montgomery_param
  import montgomery_pkg::*;
#(
  parameter int WIDTH = MONT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  logic [2:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH+1:0] c_reg;
  logic [WIDTH+1:0] c_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sub_res;
  logic             a_i;
  logic             last_bit;

  assign a_i      = a_reg[0];
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

`ifdef MONT_PRECOMP_EN
  logic [WIDTH:0]   d_reg;
  logic             q;
  logic [WIDTH+1:0] sel;

  // q is predicted so that C + sel is always even before the halving.
  always_comb begin
    q = c_reg[0] ^ (a_i & b_reg[0]);
    case ({a_i, q})
      2'b00:   sel = '0;
      2'b10:   sel = {2'b00, b_reg};
      2'b01:   sel = {2'b00, m_reg};
      default: sel = {1'b0, d_reg};
    endcase
    c_next = (c_reg + sel) >> 1;
  end
`else
  logic             phase;
  logic [WIDTH+1:0] add_term;
  logic [WIDTH+1:0] c_sum;

  always_comb begin
    if (phase) add_term = c_reg[0] ? {2'b00, m_reg} : '0;
    else       add_term = a_i ? {2'b00, b_reg} : '0;
    c_sum  = c_reg + add_term;
    c_next = phase ? (c_sum >> 1) : c_sum;
  end
`endif

  mont_cond_sub #(.WIDTH(WIDTH)) u_cond_sub (
    .c   (c_reg),
    .m   (m_reg),
    .res (sub_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      m_reg  <= '0;
      c_reg  <= '0;
      cnt    <= '0;
`ifdef MONT_PRECOMP_EN
      d_reg  <= '0;
`else
      phase  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg <= in_a;
          b_reg <= in_b;
          m_reg <= in_m;
          c_reg <= '0;
          cnt   <= '0;
`ifdef MONT_PRECOMP_EN
          state <= PRECOMP;
`else
          phase <= 1'b0;
          state <= ITER;
`endif
        end
`ifdef MONT_PRECOMP_EN
        PRECOMP: begin
          d_reg <= {1'b0, b_reg} + {1'b0, m_reg};
          state <= ITER;
        end
        ITER: begin
          c_reg <= c_next;
          a_reg <= a_reg >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) state <= SUB;
        end
`else
        ITER: begin
          c_reg <= c_next;
          phase <= ~phase;
          if (phase) begin
            a_reg <= a_reg >> 1;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) state <= SUB;
          end
        end
`endif
        SUB: begin
          result <= sub_res;
          state  <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == PRECOMP) || (state == ITER) || (state == SUB);
  assign done = (state == DONE);

endmodule

// File: tb/tb_montgomery_param.sv
// Directed vector bench for montgomery_param at WIDTH=8, plus a WIDTH=32 randomized property run.
module tb_montgomery_param;

`ifdef MONT_PRECOMP_EN
  localparam int L8  = 8 + 3;
  localparam int L32 = 32 + 3;
`else
  localparam int L8  = 2 * 8 + 2;
  localparam int L32 = 2 * 32 + 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start8, start32;
  logic [7:0]  a8, b8, m8, res8;
  logic        busy8, done8;
  logic [31:0] a32, b32, m32, res32;
  logic        busy32, done32;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  montgomery_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .in_a(a8), .in_b(b8), .in_m(m8),
    .result(res8), .busy(busy8), .done(done8)
  );

  montgomery_param #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32),
    .in_a(a32), .in_b(b32), .in_m(m32),
    .result(res32), .busy(busy32), .done(done32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one multiply on the 8-bit DUT and follow it to done; optional start re-pulse mid-flight.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                      input int repulse_at, output logic [7:0] r, output int dcyc,
                      output int busy_bad);
    @(negedge clk);
    a8 = a; b8 = b; m8 = m; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; m8 = ~m;
    dcyc = -1; busy_bad = 0;
    for (int c = 1; c <= 4 * L8 + 10 && dcyc < 0; c++) begin
      @(negedge clk);
      if (done8) begin
        dcyc = c;
        if (busy8 !== 1'b0) busy_bad++;
      end else if (busy8 !== 1'b1) begin
        busy_bad++;
      end
      if (c == repulse_at) begin
        start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
      end else begin
        start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    r = res8;
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m,
                       output logic [31:0] r, output int dcyc);
    @(negedge clk);
    a32 = a; b32 = b; m32 = m; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0; a32 = '0; b32 = '0; m32 = '0;
    dcyc = -1;
    for (int c = 1; c <= 4 * L32 + 10 && dcyc < 0; c++) begin
      @(negedge clk);
      if (done32) dcyc = c;
    end
    r = res32;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [7:0]  r8;
    logic [31:0] r32, ra, rb, rm;
    logic [63:0] lhs, rhs;
    int          dcyc, bbad, spurious;

    // Expected values: A*B*256^-1 mod M, worked by hand.
    tbl[0] = '{8'd5,   8'd7,   8'd13,  8'h01};
    tbl[1] = '{8'd12,  8'd12,  8'd13,  8'h03};
    tbl[2] = '{8'd1,   8'd1,   8'd13,  8'h03};
    tbl[3] = '{8'd0,   8'd9,   8'd13,  8'h00};
    tbl[4] = '{8'd254, 8'd254, 8'd255, 8'h01};
    tbl[5] = '{8'd6,   8'd8,   8'd11,  8'h05};
    tbl[6] = '{8'd100, 8'd200, 8'd251, 8'hEB};

    reset = 1'b1; start8 = 1'b0; start32 = 1'b0;
    a8 = '0; b8 = '0; m8 = '0; a32 = '0; b32 = '0; m32 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'd0, busy8}, 64'd0);
    check("reset_done", {63'd0, done8}, 64'd0);
    check("reset_result", {56'd0, res8}, 64'd0);
    check("reset_busy32", {63'd0, busy32}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].m, -1, r8, dcyc, bbad);
      check($sformatf("vec%0d_result", i), {56'd0, r8}, {56'd0, tbl[i].exp});
      check($sformatf("vec%0d_latency", i), 64'(dcyc), 64'(L8));
      check($sformatf("vec%0d_busy", i), 64'(bbad), 64'd0);
    end

    // Start re-pulsed mid-operation with other operands must be ignored.
    run8(8'd5, 8'd7, 8'd13, 5, r8, dcyc, bbad);
    check("repulse_result", {56'd0, r8}, 64'h01);
    check("repulse_latency", 64'(dcyc), 64'(L8));
    check("repulse_busy", 64'(bbad), 64'd0);

    // Start held during the done cycle is dropped; result is untouched.
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd1; m8 = 8'd13;
    @(negedge clk);
    start8 = 1'b0;
    check("done_start_busy", {63'd0, busy8}, 64'd0);
    @(negedge clk);
    check("done_start_busy2", {63'd0, busy8}, 64'd0);
    check("done_start_result", {56'd0, res8}, 64'h01);

    // A start right after done is accepted.
    run8(8'd12, 8'd12, 8'd13, -1, r8, dcyc, bbad);
    check("back2back_result", {56'd0, r8}, 64'h03);
    check("back2back_latency", 64'(dcyc), 64'(L8));

    // Reset mid-operation discards the multiply.
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", {63'd0, busy8}, 64'd0);
    check("midreset_done", {63'd0, done8}, 64'd0);
    check("midreset_result", {56'd0, res8}, 64'd0);
    spurious = 0;
    for (int c = 0; c < 2 * L8; c++) begin
      @(negedge clk);
      if (done8 || busy8) spurious++;
    end
    check("midreset_no_done", 64'(spurious), 64'd0);
    run8(8'd5, 8'd7, 8'd13, -1, r8, dcyc, bbad);
    check("after_reset_result", {56'd0, r8}, 64'h01);
    check("after_reset_latency", 64'(dcyc), 64'(L8));

    // 32-bit: result r must satisfy r < M and r*2^32 == A*B (mod M).
    for (int i = 0; i < 6; i++) begin
      rm = $urandom | 32'h8000_0001;
      ra = $urandom % rm;
      rb = $urandom % rm;
      run32(ra, rb, rm, r32, dcyc);
      lhs = ({32'd0, r32} << 32) % {32'd0, rm};
      rhs = ({32'd0, ra} * {32'd0, rb}) % {32'd0, rm};
      check($sformatf("w32_%0d_reduced", i), {63'd0, (r32 < rm)}, 64'd1);
      check($sformatf("w32_%0d_congruent", i), lhs, rhs);
      check($sformatf("w32_%0d_latency", i), 64'(dcyc), 64'(L32));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
